bw_r_rf32x108_qctl: RTL and testbench

//  Queue controller that sequences one 32x108 1R1W register-file macro as a 32-entry FIFO.

---
 rtl/bw_r_rf32x108_qctl_pkg.sv | 22 ++
 rtl/bw_r_rf32x108_qctl_if.sv | 55 +++++
 rtl/bw_rf_qptr.sv | 62 ++++++
 rtl/bw_r_rf32x108_qctl.sv | 92 +++++++++
 tb/tb_bw_r_rf32x108_qctl.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bw_r_rf32x108_qctl_pkg.sv
// Shared constants and types for the 32x108 register-file queue controller.
package bw_r_rf32x108_qctl_pkg;

  localparam int RF32X108_DW    = 108;
  localparam int RF32X108_AW    = 5;
  localparam int RF32X108_DEPTH = 32;
  localparam int RF32X108_WENW  = 4;

  typedef logic [RF32X108_DW-1:0]   rf_data_t;
  typedef logic [RF32X108_AW-1:0]   rf_adr_t;
  typedef logic [RF32X108_AW:0]     rf_cnt_t;
  typedef logic [RF32X108_WENW-1:0] rf_wen_t;
  typedef logic [2:0]               dbg_wait_t;

  // Occupancy thresholds in counter width.
  localparam rf_cnt_t RF32X108_FULL_CNT  = 6'd32;
  localparam rf_cnt_t RF32X108_AFULL_CNT = 6'd28;

  // Number of cycles a pending debug read may lose to dequeue.
  localparam dbg_wait_t RF32X108_DBG_MAXWAIT = 3'd4;

endpackage

// File: rtl/bw_r_rf32x108_qctl_if.sv
// Bundle of queue, diagnostic and macro-side signals around the controller.
// Handshakes: an entry moves when enq_vld & enq_rdy are high on the same clock
// edge; enq_rdy never depends on enq_vld. deq_req/dbg_req are held by the
// requester until the matching grant is seen; data follows one cycle after the
// grant, qualified by deq_vld/dbg_vld.
interface bw_r_rf32x108_qctl_if;
  import bw_r_rf32x108_qctl_pkg::*;

  logic      enq_vld;
  rf_data_t  enq_data;
  rf_wen_t   enq_wen;
  logic      enq_rdy;
  logic      deq_req;
  logic      deq_gnt;
  logic      deq_vld;
  rf_data_t  deq_data;
  logic      dbg_req;
  rf_adr_t   dbg_adr;
  logic      dbg_gnt;
  logic      dbg_vld;
  rf_data_t  dbg_data;
  rf_cnt_t   count;
  logic      empty;
  logic      full;
  logic      afull;
  dbg_wait_t dbg_wait;
  rf_data_t  rf_din;
  rf_adr_t   rf_wr_adr;
  logic      rf_wr_en;
  rf_wen_t   rf_word_wen;
  rf_adr_t   rf_rd_adr1;
  rf_adr_t   rf_rd_adr2;
  logic      rf_sel_rdaddr1;
  logic      rf_read_en;
  logic      rf_reset_l;
  rf_data_t  rf_dout;

  // Controller side.
  modport slave (
    input  enq_vld, enq_data, enq_wen, deq_req, dbg_req, dbg_adr, rf_dout,
    output enq_rdy, deq_gnt, deq_vld, deq_data, dbg_gnt, dbg_vld, dbg_data,
           count, empty, full, afull, dbg_wait,
           rf_din, rf_wr_adr, rf_wr_en, rf_word_wen, rf_rd_adr1, rf_rd_adr2,
           rf_sel_rdaddr1, rf_read_en, rf_reset_l
  );

  // Producer / consumer / macro side.
  modport master (
    output enq_vld, enq_data, enq_wen, deq_req, dbg_req, dbg_adr, rf_dout,
    input  enq_rdy, deq_gnt, deq_vld, deq_data, dbg_gnt, dbg_vld, dbg_data,
           count, empty, full, afull, dbg_wait,
           rf_din, rf_wr_adr, rf_wr_en, rf_word_wen, rf_rd_adr1, rf_rd_adr2,
           rf_sel_rdaddr1, rf_read_en, rf_reset_l
  );
endinterface

// File: rtl/bw_rf_qptr.sv
// FIFO write/read pointers, occupancy counter and registered status flags.
module bw_rf_qptr
  import bw_r_rf32x108_qctl_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_reset,
  input  logic    i_hold,
  input  logic    i_push,
  input  logic    i_pop,
  output rf_adr_t o_wr_ptr,
  output rf_adr_t o_rd_ptr,
  output rf_cnt_t o_count,
  output logic    o_empty,
  output logic    o_full,
  output logic    o_afull
);

  rf_adr_t r_wr_ptr;
  rf_adr_t r_rd_ptr;
  rf_cnt_t r_count;
  logic    r_empty;
  logic    r_full;
  logic    r_afull;
  rf_cnt_t w_count_nxt;

  // Next occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (i_push && !i_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!i_push && i_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Pointers roll over naturally at the AW-bit boundary; flags track the new count.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
    end else if (!i_hold) begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == RF32X108_FULL_CNT);
      r_afull <= (w_count_nxt >= RF32X108_AFULL_CNT);
    end
  end

  assign o_wr_ptr = r_wr_ptr;
  assign o_rd_ptr = r_rd_ptr;
  assign o_count  = r_count;
  assign o_empty  = r_empty;
  assign o_full   = r_full;
  assign o_afull  = r_afull;

endmodule

// File: rtl/bw_r_rf32x108_qctl.sv
// Sequences a 32x108 1R1W register file as a FIFO and shares its read port
// between dequeue and an aged diagnostic read path.
module bw_r_rf32x108_qctl
  import bw_r_rf32x108_qctl_pkg::*;
(
  input logic                 rclk,
  input logic                 reset,
  input logic                 sehold,
  bw_r_rf32x108_qctl_if.slave qif
);

  rf_adr_t   w_wr_ptr;
  rf_adr_t   w_rd_ptr;
  rf_cnt_t   w_count;
  logic      w_empty;
  logic      w_full;
  logic      w_afull;
  logic      w_enq_rdy;
  logic      w_wr_en;
  logic      w_deq_gnt;
  logic      w_dbg_gnt;
  logic      w_dbg_aged;
  logic      w_wr_hit;
  dbg_wait_t r_dbg_wait;
  logic      r_deq_vld;
  logic      r_dbg_vld;

  bw_rf_qptr u_qptr (
    .i_clk    (rclk),
    .i_reset  (reset),
    .i_hold   (sehold),
    .i_push   (w_wr_en),
    .i_pop    (w_deq_gnt),
    .o_wr_ptr (w_wr_ptr),
    .o_rd_ptr (w_rd_ptr),
    .o_count  (w_count),
    .o_empty  (w_empty),
    .o_full   (w_full),
    .o_afull  (w_afull)
  );

  // Grant arbitration: dequeue wins until the debug request has aged out;
  // a debug read never targets the entry being written this cycle.
  always_comb begin
    w_enq_rdy  = ~w_full & ~sehold & ~reset;
    w_wr_en    = qif.enq_vld & w_enq_rdy;
    w_dbg_aged = (r_dbg_wait >= RF32X108_DBG_MAXWAIT);
    w_wr_hit   = w_wr_en & (qif.dbg_adr == w_wr_ptr);
    w_deq_gnt  = qif.deq_req & ~w_empty & ~sehold & ~reset & (~qif.dbg_req | ~w_dbg_aged);
    w_dbg_gnt  = qif.dbg_req & ~w_deq_gnt & ~sehold & ~reset & ~w_wr_hit;
  end

  // Read-data valids trail the grants by one cycle; debug age saturates.
  always_ff @(posedge rclk) begin
    if (reset) begin
      r_deq_vld  <= 1'b0;
      r_dbg_vld  <= 1'b0;
      r_dbg_wait <= '0;
    end else if (!sehold) begin
      r_deq_vld <= w_deq_gnt;
      r_dbg_vld <= w_dbg_gnt;
      if (w_dbg_gnt) begin
        r_dbg_wait <= '0;
      end else if (qif.dbg_req && !w_dbg_aged) begin
        r_dbg_wait <= r_dbg_wait + 1'b1;
      end
    end
  end

  assign qif.enq_rdy        = w_enq_rdy;
  assign qif.deq_gnt        = w_deq_gnt;
  assign qif.deq_vld        = r_deq_vld;
  assign qif.deq_data       = qif.rf_dout;
  assign qif.dbg_gnt        = w_dbg_gnt;
  assign qif.dbg_vld        = r_dbg_vld;
  assign qif.dbg_data       = qif.rf_dout;
  assign qif.count          = w_count;
  assign qif.empty          = w_empty;
  assign qif.full           = w_full;
  assign qif.afull          = w_afull;
  assign qif.dbg_wait       = r_dbg_wait;
  assign qif.rf_din         = qif.enq_data;
  assign qif.rf_wr_adr      = w_wr_ptr;
  assign qif.rf_wr_en       = w_wr_en;
  assign qif.rf_word_wen    = qif.enq_wen;
  assign qif.rf_rd_adr1     = w_rd_ptr;
  assign qif.rf_rd_adr2     = qif.dbg_adr;
  assign qif.rf_sel_rdaddr1 = w_deq_gnt;
  assign qif.rf_read_en     = w_deq_gnt | w_dbg_gnt;
  assign qif.rf_reset_l     = ~reset;

endmodule

// File: tb/tb_bw_r_rf32x108_qctl.sv
// Bench for the register-file queue controller, with a behavioural macro and
// a queue-based reference model of the FIFO and read arbitration.
module tb_bw_r_rf32x108_qctl;
  import bw_r_rf32x108_qctl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic sehold;
  always #5 clk = ~clk;

  bw_r_rf32x108_qctl_if qif();

  bw_r_rf32x108_qctl dut (
    .rclk   (clk),
    .reset  (reset),
    .sehold (sehold),
    .qif    (qif)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- macro model ----------------
  logic [107:0] mem [32] = '{default: '0};
  logic [4:0]   rd_q = '0;

  function automatic logic [107:0] lane_mask(input logic [3:0] wen);
    logic [107:0] m;
    for (int b = 0; b < 108; b++) m[b] = wen[b % 4];
    return m;
  endfunction

  always @(posedge clk) begin
    if (qif.rf_wr_en)
      mem[qif.rf_wr_adr] <= (mem[qif.rf_wr_adr] & ~lane_mask(qif.rf_word_wen)) |
                            (qif.rf_din & lane_mask(qif.rf_word_wen));
    if (qif.rf_read_en)
      rd_q <= qif.rf_sel_rdaddr1 ? qif.rf_rd_adr1 : qif.rf_rd_adr2;
  end
  assign qif.rf_dout = mem[rd_q];

  // ---------------- reference model ----------------
  logic [107:0] exp_q[$];
  logic [107:0] m_arr [32] = '{default: '0};
  int           m_wp, m_rp, m_wait;
  logic         m_deq_vld, m_dbg_vld;
  logic [107:0] m_deq_data, m_dbg_data;

  function automatic logic [107:0] rnd108();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[107:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; sehold = 1'b0;
    qif.enq_vld = 1'b1; qif.deq_req = 1'b1; qif.dbg_req = 1'b1;
    qif.enq_data = '0; qif.enq_wen = 4'hF; qif.dbg_adr = '0;
    #1;
    checks++;
    if ({qif.deq_gnt, qif.dbg_gnt, qif.enq_rdy, qif.rf_wr_en, qif.rf_read_en, qif.rf_reset_l} !== 6'b0) begin
      errors++;
      $display("FAIL in_reset got=%b exp=000000", {qif.deq_gnt, qif.dbg_gnt, qif.enq_rdy,
               qif.rf_wr_en, qif.rf_read_en, qif.rf_reset_l});
    end
    @(negedge clk);
    reset = 1'b0;
    qif.enq_vld = 1'b0; qif.deq_req = 1'b0; qif.dbg_req = 1'b0;
    #1;
    exp_q.delete();
    m_wp = 0; m_rp = 0; m_wait = 0; m_deq_vld = 1'b0; m_dbg_vld = 1'b0;
    checks++;
    if ({qif.count, qif.empty, qif.full, qif.afull, qif.deq_vld, qif.dbg_vld,
         qif.rf_wr_adr, qif.rf_rd_adr1, qif.dbg_wait, qif.rf_reset_l} !==
        {6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL after_reset count=%0d empty=%b full=%b afull=%b dv=%b bv=%b wa=%0d ra=%0d wait=%0d (exp 0 1 0 0 0 0 0 0 0)",
               qif.count, qif.empty, qif.full, qif.afull, qif.deq_vld, qif.dbg_vld,
               qif.rf_wr_adr, qif.rf_rd_adr1, qif.dbg_wait);
    end
  endtask

  // One clock of stimulus; every DUT output is compared against the model.
  task automatic step(input logic ev, input logic [107:0] ed, input logic [3:0] ew,
                      input logic dr, input logic br, input logic [4:0] ba, input logic sh,
                      output logic o_dg, output logic o_bg);
    int   cnt;
    logic e_rdy, e_wr, e_dg, e_bg;
    logic [107:0] mk;
    @(negedge clk);
    qif.enq_vld = ev; qif.enq_data = ed; qif.enq_wen = ew;
    qif.deq_req = dr; qif.dbg_req = br; qif.dbg_adr = ba; sehold = sh;
    #1;
    cnt   = exp_q.size();
    e_rdy = (cnt != 32) && !sh;
    e_wr  = ev && e_rdy;
    e_dg  = dr && (cnt != 0) && !sh && (!br || m_wait < 4);
    e_bg  = br && !e_dg && !sh && !(e_wr && (ba == 5'(m_wp)));
    checks++;
    if ({qif.deq_gnt, qif.dbg_gnt, qif.enq_rdy, qif.rf_wr_en, qif.rf_read_en,
         qif.empty, qif.full, qif.afull, qif.deq_vld, qif.dbg_vld} !==
        {e_dg, e_bg, e_rdy, e_wr, e_dg | e_bg, cnt == 0, cnt == 32, cnt >= 28,
         m_deq_vld, m_dbg_vld}) begin
      errors++;
      $display("FAIL ctl t=%0t got=%b exp=%b", $time,
               {qif.deq_gnt, qif.dbg_gnt, qif.enq_rdy, qif.rf_wr_en, qif.rf_read_en,
                qif.empty, qif.full, qif.afull, qif.deq_vld, qif.dbg_vld},
               {e_dg, e_bg, e_rdy, e_wr, e_dg | e_bg, cnt == 0, cnt == 32, cnt >= 28,
                m_deq_vld, m_dbg_vld});
    end
    checks++;
    if ({qif.count, qif.rf_wr_adr, qif.rf_rd_adr1, qif.rf_rd_adr2, qif.dbg_wait} !==
        {6'(cnt), 5'(m_wp), 5'(m_rp), ba, 3'(m_wait)}) begin
      errors++;
      $display("FAIL state t=%0t count=%0d wa=%0d ra=%0d ra2=%0d wait=%0d exp %0d %0d %0d %0d %0d",
               $time, qif.count, qif.rf_wr_adr, qif.rf_rd_adr1, qif.rf_rd_adr2, qif.dbg_wait,
               cnt, m_wp, m_rp, ba, m_wait);
    end
    if (e_dg || e_bg) begin
      checks++;
      if (qif.rf_sel_rdaddr1 !== e_dg) begin
        errors++;
        $display("FAIL sel t=%0t got=%b exp=%b", $time, qif.rf_sel_rdaddr1, e_dg);
      end
    end
    if (e_wr) begin
      checks++;
      if ({qif.rf_din, qif.rf_word_wen} !== {ed, ew}) begin
        errors++;
        $display("FAIL wr_bus t=%0t din=%h wen=%h exp %h %h", $time, qif.rf_din, qif.rf_word_wen, ed, ew);
      end
    end
    if (m_deq_vld) begin
      checks++;
      if (qif.deq_data !== m_deq_data) begin
        errors++;
        $display("FAIL deq_data t=%0t got=%h exp=%h", $time, qif.deq_data, m_deq_data);
      end
    end
    if (m_dbg_vld) begin
      checks++;
      if (qif.dbg_data !== m_dbg_data) begin
        errors++;
        $display("FAIL dbg_data t=%0t got=%h exp=%h", $time, qif.dbg_data, m_dbg_data);
      end
    end
    // advance the model to the state after the coming edge
    if (e_bg) m_dbg_data = m_arr[ba];
    if (e_dg) begin
      m_deq_data = exp_q.pop_front();
      m_rp = (m_rp + 1) % 32;
    end
    if (e_wr) begin
      mk = lane_mask(ew);
      m_arr[m_wp] = (m_arr[m_wp] & ~mk) | (ed & mk);
      exp_q.push_back(m_arr[m_wp]);
      m_wp = (m_wp + 1) % 32;
    end
    if (!sh) begin
      m_deq_vld = e_dg;
      m_dbg_vld = e_bg;
      if (e_bg) m_wait = 0;
      else if (br && m_wait < 4) m_wait = m_wait + 1;
    end
    o_dg = qif.deq_gnt;
    o_bg = qif.dbg_gnt;
  endtask

  task automatic idle();
    logic dg, bg;
    step(1'b0, '0, 4'h0, 1'b0, 1'b0, 5'd0, 1'b0, dg, bg);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_fill();
    logic dg, bg;
    do_reset();
    for (int i = 1; i <= 32; i++) step(1'b1, 108'(i), 4'hF, 1'b0, 1'b0, 5'd0, 1'b0, dg, bg);
    step(1'b1, 108'hBAD, 4'hF, 1'b0, 1'b0, 5'd0, 1'b0, dg, bg);
    checks++;
    if ({qif.full, qif.enq_rdy, qif.count, qif.rf_wr_adr} !== {1'b1, 1'b0, 6'd32, 5'd0}) begin
      errors++;
      $display("FAIL fill full=%b rdy=%b count=%0d wa=%0d exp 1 0 32 0",
               qif.full, qif.enq_rdy, qif.count, qif.rf_wr_adr);
    end
  endtask

  task automatic test_full_both();
    logic dg, bg;
    step(1'b1, 108'hBEEF, 4'hF, 1'b1, 1'b0, 5'd0, 1'b0, dg, bg);
    checks++;
    if ({dg, qif.enq_rdy, qif.rf_wr_en} !== 3'b100) begin
      errors++;
      $display("FAIL full_both dg=%b rdy=%b wen=%b exp 1 0 0", dg, qif.enq_rdy, qif.rf_wr_en);
    end
    idle();
    checks++;
    if ({qif.count, qif.deq_vld, qif.deq_data} !== {6'd31, 1'b1, 108'h1}) begin
      errors++;
      $display("FAIL full_both_after count=%0d dv=%b data=%h exp 31 1 1", qif.count, qif.deq_vld, qif.deq_data);
    end
    for (int i = 0; i < 6; i++) step(1'b0, '0, 4'h0, 1'b1, 1'b0, 5'd0, 1'b0, dg, bg);
  endtask

  task automatic test_latency();
    logic dg, bg;
    logic [107:0] a;
    do_reset();
    a = rnd108();
    step(1'b1, a, 4'hF, 1'b0, 1'b0, 5'd0, 1'b0, dg, bg);
    step(1'b0, '0, 4'h0, 1'b1, 1'b0, 5'd0, 1'b0, dg, bg);
    checks++;
    if (dg !== 1'b1) begin
      errors++;
      $display("FAIL latency_gnt got=%b exp=1", dg);
    end
    idle();
    checks++;
    if ({qif.deq_vld, qif.deq_data} !== {1'b1, a}) begin
      errors++;
      $display("FAIL latency_data vld=%b data=%h exp 1 %h", qif.deq_vld, qif.deq_data, a);
    end
    idle();
  endtask

  task automatic test_dbg_starve();
    logic dg, bg;
    logic [107:0] v, v5;
    do_reset();
    v5 = '0;
    for (int i = 0; i < 8; i++) begin
      v = rnd108();
      if (i == 5) v5 = v;
      step(1'b1, v, 4'hF, 1'b0, 1'b0, 5'd0, 1'b0, dg, bg);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 4'h0, 1'b1, 1'b1, 5'd5, 1'b0, dg, bg);
      checks++;
      if ({dg, bg} !== {i < 4, i == 4}) begin
        errors++;
        $display("FAIL dbg_starve cyc=%0d dg=%b bg=%b exp %b %b", i, dg, bg, i < 4, i == 4);
      end
    end
    idle();
    checks++;
    if ({qif.dbg_vld, qif.dbg_data} !== {1'b1, v5}) begin
      errors++;
      $display("FAIL dbg_starve_data vld=%b data=%h exp 1 %h", qif.dbg_vld, qif.dbg_data, v5);
    end
  endtask

  task automatic test_collision();
    logic dg, bg;
    logic [107:0] nd;
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, rnd108(), 4'hF, 1'b0, 1'b0, 5'd0, 1'b0, dg, bg);
    nd = rnd108();
    step(1'b1, nd, 4'hF, 1'b0, 1'b1, 5'd7, 1'b0, dg, bg);
    checks++;
    if ({bg, qif.rf_wr_en, qif.rf_wr_adr} !== {1'b0, 1'b1, 5'd7}) begin
      errors++;
      $display("FAIL collision bg=%b wen=%b wa=%0d exp 0 1 7", bg, qif.rf_wr_en, qif.rf_wr_adr);
    end
    step(1'b0, '0, 4'h0, 1'b0, 1'b1, 5'd7, 1'b0, dg, bg);
    checks++;
    if (bg !== 1'b1) begin
      errors++;
      $display("FAIL collision_retry bg=%b exp 1", bg);
    end
    idle();
    checks++;
    if ({qif.dbg_vld, qif.dbg_data} !== {1'b1, nd}) begin
      errors++;
      $display("FAIL collision_data vld=%b data=%h exp 1 %h", qif.dbg_vld, qif.dbg_data, nd);
    end
  endtask

  task automatic test_sehold();
    logic dg, bg;
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, rnd108(), 4'hF, 1'b0, 1'b0, 5'd0, 1'b0, dg, bg);
    step(1'b1, rnd108(), 4'hF, 1'b1, 1'b0, 5'd0, 1'b0, dg, bg);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, rnd108(), 4'hF, 1'b1, 1'b1, 5'd2, 1'b1, dg, bg);
      checks++;
      if ({dg, bg, qif.enq_rdy, qif.count, qif.deq_vld} !== {3'b000, 6'd5, 1'b1}) begin
        errors++;
        $display("FAIL sehold cyc=%0d dg=%b bg=%b rdy=%b count=%0d dv=%b exp 0 0 0 5 1",
                 i, dg, bg, qif.enq_rdy, qif.count, qif.deq_vld);
      end
    end
    do_reset();
  endtask

  task automatic test_random();
    logic dg, bg, pend, ev, dr, sh;
    logic [4:0] pa;
    pend = 1'b0; pa = '0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      ev = ($urandom_range(0, 99) < 55);
      dr = ($urandom_range(0, 99) < 50);
      sh = ($urandom_range(0, 99) < 5);
      if (!pend) begin
        pend = ($urandom_range(0, 99) < 25);
        pa   = 5'($urandom_range(0, 31));
      end
      step(ev, rnd108(), 4'($urandom_range(0, 15)), dr, pend, pa, sh, dg, bg);
      if (bg) pend = 1'b0;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; sehold = 1'b0;
    qif.enq_vld = 1'b0; qif.enq_data = '0; qif.enq_wen = '0;
    qif.deq_req = 1'b0; qif.dbg_req = 1'b0; qif.dbg_adr = '0;
    m_wp = 0; m_rp = 0; m_wait = 0; m_deq_vld = 1'b0; m_dbg_vld = 1'b0;
    m_deq_data = '0; m_dbg_data = '0;
    test_reset();
    test_fill();
    test_full_both();
    test_latency();
    test_dbg_starve();
    test_collision();
    test_sehold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
